// File: rtl/mips_cpu_data_bridge_if.sv
// CPU-side load/store request and Avalon-MM data-master signals of the MIPS data bridge.
// slave = the bridge's view; master = the environment (core + bus slave) driving it.
interface mips_cpu_data_bridge_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [3:0]  cpu_byte_enable;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_writedata;
    logic        cpu_signextend;
    logic        cpu_stall;
    logic        cpu_done;
    logic [31:0] cpu_readdata;

    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    logic        bus_error;

    modport slave (
        input  cpu_read, cpu_write, cpu_byte_enable, cpu_addr, cpu_writedata, cpu_signextend,
        input  avm_waitrequest, avm_readdata,
        output cpu_stall, cpu_done, cpu_readdata,
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        output bus_error
    );

    modport master (
        output cpu_read, cpu_write, cpu_byte_enable, cpu_addr, cpu_writedata, cpu_signextend,
        output avm_waitrequest, avm_readdata,
        input  cpu_stall, cpu_done, cpu_readdata,
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        input  bus_error
    );
endinterface

// File: rtl/mips_cpu_data_bridge.sv
// Data-side bus responder: turns a held CPU load/store into one Avalon-MM transfer, retiring 2 cycles
// after the request plus one per waitrequest cycle; the core is stalled throughout and MAX_WAIT aborts.
module mips_cpu_data_bridge #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    mips_cpu_data_bridge_if.slave        bus
);
    localparam int unsigned              CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]         WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]         WAIT_LAST  = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [31:0]        avm_address_q;
    logic               avm_read_q;
    logic               avm_write_q;
    logic [3:0]         avm_byteenable_q;
    logic [31:0]        avm_writedata_q;
    logic [31:0]        cpu_readdata_q;
    logic               cpu_done_q;
    logic               bus_error_q;
    logic [1:0]         lane_q;
    logic [3:0]         size_q;
    logic               sext_q;

    logic [1:0]         req_lane;
    logic               req_any;
    logic               req_one;
    logic               size_legal;
    logic               req_aligned;
    logic               req_valid;
    logic [3:0]         req_be;
    logic [31:0]        req_wd;
    logic [31:0]        rd_shift;
    logic [31:0]        load_ext;

    // Request decode: only one strobe, a legal size and natural alignment get onto the bus.
    assign req_lane   = bus.cpu_addr[1:0];
    assign req_any    = bus.cpu_read | bus.cpu_write;
    assign req_one    = bus.cpu_read ^ bus.cpu_write;
    assign size_legal = (bus.cpu_byte_enable == 4'b0001) ||
                        (bus.cpu_byte_enable == 4'b0011) ||
                        (bus.cpu_byte_enable == 4'b1111);

    always_comb begin
        req_aligned = 1'b0;
        case (bus.cpu_byte_enable)
            4'b0001: req_aligned = 1'b1;
            4'b0011: req_aligned = ~req_lane[0];
            4'b1111: req_aligned = (req_lane == 2'b00);
            default: req_aligned = 1'b0;
        endcase
    end

    assign req_valid = req_one & size_legal & req_aligned;
    assign req_be    = bus.cpu_byte_enable << req_lane;
    assign req_wd    = bus.cpu_writedata << {req_lane, 3'b000};

    // Load path: bring the addressed lane down to bit 0, then extend from the access's top bit.
    assign rd_shift = bus.avm_readdata >> {lane_q, 3'b000};

    always_comb begin
        load_ext = rd_shift;
        case (size_q)
            4'b0001: load_ext = {{24{sext_q & rd_shift[7]}},  rd_shift[7:0]};
            4'b0011: load_ext = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            wait_cnt_q       <= '0;
            avm_address_q    <= 32'd0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_byteenable_q <= 4'd0;
            avm_writedata_q  <= 32'd0;
            cpu_readdata_q   <= 32'd0;
            cpu_done_q       <= 1'b0;
            bus_error_q      <= 1'b0;
            lane_q           <= 2'd0;
            size_q           <= 4'd0;
            sext_q           <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_any) begin
                        if (req_valid) begin
                            avm_address_q    <= {bus.cpu_addr[31:2], 2'b00};
                            avm_byteenable_q <= req_be;
                            avm_writedata_q  <= req_wd;
                            avm_read_q       <= bus.cpu_read;
                            avm_write_q      <= bus.cpu_write;
                            lane_q           <= req_lane;
                            size_q           <= bus.cpu_byte_enable;
                            sext_q           <= bus.cpu_signextend;
                            wait_cnt_q       <= '0;
                            state_q          <= S_BUS;
                        end else begin
                            // Rejected request: answer straight away without touching the bus.
                            bus_error_q    <= 1'b1;
                            cpu_readdata_q <= 32'd0;
                            cpu_done_q     <= 1'b1;
                            state_q        <= S_RESP;
                        end
                    end
                end

                S_BUS: begin
                    if (bus.avm_waitrequest) begin
                        if (wait_cnt_q == WAIT_LAST) begin
                            avm_read_q     <= 1'b0;
                            avm_write_q    <= 1'b0;
                            bus_error_q    <= 1'b1;
                            cpu_readdata_q <= 32'd0;
                            cpu_done_q     <= 1'b1;
                            state_q        <= S_RESP;
                        end else if (wait_cnt_q != WAIT_LIMIT) begin
                            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        if (avm_read_q) begin
                            cpu_readdata_q <= load_ext;
                        end
                        avm_read_q  <= 1'b0;
                        avm_write_q <= 1'b0;
                        cpu_done_q  <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end

                S_RESP: begin
                    cpu_done_q <= 1'b0;
                    state_q    <= S_IDLE;
                end

                default: begin
                    cpu_done_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // Stall is gated by reset so it drops at once when reset hits with a request still held.
    assign bus.cpu_stall      = reset & (((state_q == S_IDLE) & req_any) | (state_q == S_BUS));
    assign bus.cpu_done       = cpu_done_q;
    assign bus.cpu_readdata   = cpu_readdata_q;
    assign bus.avm_address    = avm_address_q;
    assign bus.avm_read       = avm_read_q;
    assign bus.avm_write      = avm_write_q;
    assign bus.avm_byteenable = avm_byteenable_q;
    assign bus.avm_writedata  = avm_writedata_q;
    assign bus.bus_error      = bus_error_q;

    a_one_strobe: assert property (@(posedge clk) disable iff (!reset) !(avm_read_q && avm_write_q));
    a_done_pulse: assert property (@(posedge clk) disable iff (!reset) cpu_done_q |=> !cpu_done_q);

endmodule

// File: tb/tb_mips_cpu_data_bridge.sv
// Bench for mips_cpu_data_bridge: directed table, timeout and async-reset sequences, then random
// accesses checked against a lane/extension model computed from plain address arithmetic.
module tb_mips_cpu_data_bridge;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_cpu_data_bridge_if bus_if();

    mips_cpu_data_bridge #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        sext;
        int          nwait;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        int          done;
        int          strobes;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        req_t req;
        exp_t exp;
    } vec_t;

    typedef struct {
        int          done;
        int          stall;
        int          strobes;
        logic        stable;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        was_rd;
        logic        was_wr;
        logic [31:0] rdata;
        logic        err;
    } obs_t;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model_rdata;
    logic        model_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic sext,
                                input int nwait, input logic [31:0] rdata,
                                input int done, input int strobes, input logic [31:0] eaddr,
                                input logic [3:0] ebe, input logic [31:0] ewd,
                                input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.req = '{rd: rd, wr: wr, be: be, addr: addr, wdata: wdata, sext: sext, nwait: nwait, rdata: rdata};
        v.exp = '{done: done, strobes: strobes, addr: eaddr, be: ebe, wd: ewd, rdata: erd, err: eerr};
        return v;
    endfunction

    // Reference: what the access should look like, from the little-endian lane rules.
    task automatic predict(input req_t r, output exp_t e);
        int          o;
        logic        size_ok;
        logic        align_ok;
        logic [31:0] s;
        logic [31:0] v;
        o        = int'(r.addr % 4);
        size_ok  = (r.be == 4'd1) || (r.be == 4'd3) || (r.be == 4'd15);
        align_ok = (r.be == 4'd1) || (r.be == 4'd3 && (o % 2) == 0) || (r.be == 4'd15 && o == 0);
        e.addr   = r.addr - 32'(o);
        e.be     = 4'((32'(r.be) << o) & 32'hF);
        e.wd     = r.wdata << (8 * o);
        if (!((r.rd != r.wr) && size_ok && align_ok)) begin
            e.done = 1; e.strobes = 0; model_err = 1'b1; model_rdata = 32'd0;
        end else if (r.nwait >= MAX_WAIT) begin
            e.done = MAX_WAIT + 1; e.strobes = MAX_WAIT; model_err = 1'b1; model_rdata = 32'd0;
        end else begin
            e.done = 2 + r.nwait; e.strobes = r.nwait + 1;
            if (r.rd) begin
                s = r.rdata >> (8 * o);
                if (r.be == 4'd1) begin
                    v = s % 256;
                    if (r.sext && v >= 128) v = v + 32'hFFFFFF00;
                end else if (r.be == 4'd3) begin
                    v = s % 65536;
                    if (r.sext && v >= 32768) v = v + 32'hFFFF0000;
                end else begin
                    v = s;
                end
                model_rdata = v;
            end
        end
        e.rdata = model_rdata;
        e.err   = model_err;
    endtask

    // Called at posedge+1 of the request cycle; returns at posedge+1 of the cycle after RESP.
    task automatic run_access(input req_t r, output obs_t o);
        o = '{done: -1, stall: 0, strobes: 0, stable: 1'b1, addr: 32'd0, be: 4'd0, wd: 32'd0,
              was_rd: 1'b0, was_wr: 1'b0, rdata: 32'd0, err: 1'b0};
        bus_if.cpu_read        = r.rd;
        bus_if.cpu_write       = r.wr;
        bus_if.cpu_byte_enable = r.be;
        bus_if.cpu_addr        = r.addr;
        bus_if.cpu_writedata   = r.wdata;
        bus_if.cpu_signextend  = r.sext;
        bus_if.avm_readdata    = r.rdata;
        for (int cyc = 0; cyc < 40 && o.done < 0; cyc++) begin
            bus_if.avm_waitrequest = (cyc >= 1 && cyc <= r.nwait);
            @(negedge clk);
            if (bus_if.cpu_stall) o.stall++;
            if (bus_if.avm_read || bus_if.avm_write) begin
                if (o.strobes == 0) begin
                    o.addr = bus_if.avm_address; o.be = bus_if.avm_byteenable;
                    o.wd = bus_if.avm_writedata; o.was_rd = bus_if.avm_read; o.was_wr = bus_if.avm_write;
                end else if (o.addr !== bus_if.avm_address || o.be !== bus_if.avm_byteenable ||
                             o.wd !== bus_if.avm_writedata || o.was_rd !== bus_if.avm_read ||
                             o.was_wr !== bus_if.avm_write) begin
                    o.stable = 1'b0;
                end
                o.strobes++;
            end
            if (bus_if.cpu_done) begin
                o.done  = cyc;
                o.rdata = bus_if.cpu_readdata;
                o.err   = bus_if.bus_error;
            end
            @(posedge clk);
            #1;
        end
        bus_if.cpu_read        = 1'b0;
        bus_if.cpu_write       = 1'b0;
        bus_if.avm_waitrequest = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, ".idle_stall"}, 32'(bus_if.cpu_stall), 32'd0);
        check({tag, ".idle_strobes"}, 32'({bus_if.avm_read, bus_if.avm_write}), 32'd0);
        check({tag, ".idle_done"}, 32'(bus_if.cpu_done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_vector(input string tag, input req_t r, input exp_t e);
        obs_t o;
        run_access(r, o);
        check({tag, ".done_cycle"}, 32'(o.done), 32'(e.done));
        check({tag, ".stall_cycles"}, 32'(o.stall), 32'(e.done));
        check({tag, ".strobe_cycles"}, 32'(o.strobes), 32'(e.strobes));
        if (e.strobes > 0) begin
            check({tag, ".avm_address"}, o.addr, e.addr);
            check({tag, ".avm_byteenable"}, 32'(o.be), 32'(e.be));
            check({tag, ".avm_read"}, 32'(o.was_rd), 32'(r.rd));
            check({tag, ".avm_write"}, 32'(o.was_wr), 32'(r.wr));
            check({tag, ".avm_stable"}, 32'(o.stable), 32'd1);
            if (r.wr) check({tag, ".avm_writedata"}, o.wd, e.wd);
        end
        check({tag, ".cpu_readdata"}, o.rdata, e.rdata);
        check({tag, ".bus_error"}, 32'(o.err), 32'(e.err));
        idle_check(tag);
    endtask

    vec_t tbl[13];

    initial begin
        req_t r;
        exp_t e;
        int   k;

        tbl[0]  = mk(1, 0, 4'hF, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 2, 1, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0);
        tbl[1]  = mk(1, 0, 4'h1, 32'h103, 32'h0, 1, 0, 32'h80FFFFFF, 2, 1, 32'h100, 4'h8, 32'h0, 32'hFFFFFF80, 0);
        tbl[2]  = mk(1, 0, 4'h1, 32'h103, 32'h0, 0, 0, 32'h80FFFFFF, 2, 1, 32'h100, 4'h8, 32'h0, 32'h00000080, 0);
        tbl[3]  = mk(0, 1, 4'h3, 32'h202, 32'h0000ABCD, 0, 3, 32'h0, 5, 4, 32'h200, 4'hC, 32'hABCD0000, 32'h00000080, 0);
        tbl[4]  = mk(1, 0, 4'hF, 32'h101, 32'h0, 0, 0, 32'h12345678, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        tbl[5]  = mk(1, 0, 4'h3, 32'h306, 32'h0, 1, 0, 32'h80017FFF, 2, 1, 32'h304, 4'hC, 32'h0, 32'hFFFF8001, 1);
        tbl[6]  = mk(0, 1, 4'h1, 32'h007, 32'h12345678, 0, 1, 32'h0, 3, 2, 32'h004, 4'h8, 32'h78000000, 32'hFFFF8001, 1);
        tbl[7]  = mk(1, 1, 4'hF, 32'h010, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        tbl[8]  = mk(1, 0, 4'h7, 32'h000, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        tbl[9]  = mk(1, 0, 4'h3, 32'h003, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        tbl[10] = mk(1, 0, 4'h3, 32'h002, 32'h0, 0, 2, 32'hFEDC1234, 4, 3, 32'h000, 4'hC, 32'h0, 32'h0000FEDC, 1);
        tbl[11] = mk(0, 1, 4'h1, 32'h021, 32'h000000A5, 0, 0, 32'h0, 2, 1, 32'h020, 4'h2, 32'h0000A500, 32'h0000FEDC, 1);
        tbl[12] = mk(1, 0, 4'hF, 32'h080, 32'h0, 0, 3, 32'h13579BDF, 5, 4, 32'h080, 4'hF, 32'h0, 32'h13579BDF, 1);

        bus_if.cpu_read = 1'b0; bus_if.cpu_write = 1'b0; bus_if.cpu_byte_enable = 4'h0;
        bus_if.cpu_addr = 32'h0; bus_if.cpu_writedata = 32'h0; bus_if.cpu_signextend = 1'b0;
        bus_if.avm_waitrequest = 1'b0; bus_if.avm_readdata = 32'h0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.stall", 32'(bus_if.cpu_stall), 32'd0);
        check("reset.done", 32'(bus_if.cpu_done), 32'd0);
        check("reset.readdata", bus_if.cpu_readdata, 32'd0);
        check("reset.strobes", 32'({bus_if.avm_read, bus_if.avm_write}), 32'd0);
        check("reset.address", bus_if.avm_address, 32'd0);
        check("reset.byteenable", 32'(bus_if.avm_byteenable), 32'd0);
        check("reset.writedata", bus_if.avm_writedata, 32'd0);
        check("reset.bus_error", 32'(bus_if.bus_error), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        idle_check("post_reset");

        for (int i = 0; i < 13; i++) begin
            do_vector($sformatf("tbl%0d", i), tbl[i].req, tbl[i].exp);
        end

        // Slave never releases waitrequest: abort after MAX_WAIT strobe cycles.
        r = '{rd: 1'b1, wr: 1'b0, be: 4'hF, addr: 32'h40, wdata: 32'h0, sext: 1'b0, nwait: 100, rdata: 32'hCAFEF00D};
        e = '{done: MAX_WAIT + 1, strobes: MAX_WAIT, addr: 32'h40, be: 4'hF, wd: 32'h0, rdata: 32'h0, err: 1'b1};
        do_vector("timeout", r, e);

        // Asynchronous reset in the middle of a stalled read.
        bus_if.cpu_read = 1'b1; bus_if.cpu_byte_enable = 4'hF; bus_if.cpu_addr = 32'h50;
        bus_if.avm_waitrequest = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midbus.read_before", 32'(bus_if.avm_read), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midbus.read", 32'(bus_if.avm_read), 32'd0);
        check("midbus.stall", 32'(bus_if.cpu_stall), 32'd0);
        check("midbus.done", 32'(bus_if.cpu_done), 32'd0);
        check("midbus.bus_error", 32'(bus_if.bus_error), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus_if.cpu_read = 1'b0;
        bus_if.avm_waitrequest = 1'b0;
        idle_check("after_reset");
        model_rdata = 32'd0;
        model_err   = 1'b0;
        r = '{rd: 1'b1, wr: 1'b0, be: 4'h3, addr: 32'h56, wdata: 32'h0, sext: 1'b1, nwait: 1, rdata: 32'h9ABC0000};
        predict(r, e);
        do_vector("after_reset.read", r, e);

        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 9);
            r.rd    = (k < 5) || (k == 9);
            r.wr    = (k >= 5);
            k = $urandom_range(0, 7);
            r.be    = (k < 3) ? 4'h1 : (k < 5) ? 4'h3 : (k < 7) ? 4'hF : 4'($urandom_range(0, 15));
            r.addr  = $urandom;
            r.wdata = $urandom;
            r.sext  = 1'($urandom_range(0, 1));
            r.nwait = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 6);
            r.rdata = $urandom;
            predict(r, e);
            do_vector($sformatf("rand%0d", i), r, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1);
    end

endmodule
